// File: rtl/sram_ctrl_pkg.sv
// Shared widths and record types for the SRAM access controller.
// Requests carry {we, addr, wdata}; responses carry {addr, rdata}.
package sram_ctrl_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

endpackage

// File: rtl/sram_ctrl_fifo.sv
// Synchronous FIFO with occupancy count, used for both the request and response queues.
// Head is read combinationally; a push while full is accepted only if a pop happens in the same cycle.
module sram_ctrl_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             driver_clk,
    input  logic             resetn,
    input  logic             push,
    input  T                 push_data,
    input  logic             pop,
    output T                 head,
    output logic [CNT_W-1:0] count
);

    T                 mem_q [DEPTH];
    T                 mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge driver_clk or posedge resetn) begin
        if (resetn) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/sram_access_ctrl.sv
// Request-side controller for the 8x32 flop SRAM: queues client requests, issues one op per
// cycle in order, and returns read data through a 2-entry response FIFO guarded by a credit check.
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int REQ_DEPTH = 4
) (
    input  logic              driver_clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_add,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy
);

    localparam int REQ_CNT_W = $clog2(REQ_DEPTH) + 1;

    req_t                 req_push_data, req_head;
    rsp_t                 rsp_push_data, rsp_head;
    logic [REQ_CNT_W-1:0] req_count;
    logic [1:0]           rsp_count, rsp_left;
    logic                 req_push, rsp_pop, req_nonempty, credit_ok, issue;
    logic                 inflight_q, inflight_d;
    logic [ADDR_W-1:0]    inflight_addr_q, inflight_addr_d;

    assign req_ready     = (req_count != REQ_CNT_W'(REQ_DEPTH)) && !resetn;
    assign req_push      = req_valid && req_ready;
    assign req_push_data = '{we: req_we, addr: req_addr, wdata: req_wdata};
    assign req_nonempty  = (req_count != '0);

    assign rsp_valid = (rsp_count != 2'd0);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_addr  = rsp_valid ? rsp_head.addr : '0;
    assign rsp_rdata = rsp_valid ? rsp_head.rdata : '0;

    // A read may issue only if its response will find a free slot once the in-flight read lands.
    assign rsp_left  = rsp_count - {1'b0, rsp_pop};
    assign credit_ok = (rsp_left + {1'b0, inflight_q}) < 2'd2;
    assign issue     = req_nonempty && (req_head.we || credit_ok);

    assign mem_we  = issue && req_head.we;
    assign mem_add = req_nonempty ? req_head.addr : '0;
    assign mem_wd  = req_nonempty ? req_head.wdata : '0;

    assign rsp_push_data = '{addr: inflight_addr_q, rdata: mem_rd};
    assign busy          = req_nonempty || inflight_q || rsp_valid;

    always_comb begin
        inflight_d      = issue && !req_head.we;
        inflight_addr_d = inflight_d ? req_head.addr : inflight_addr_q;
    end

    always_ff @(posedge driver_clk or posedge resetn) begin
        if (resetn) begin
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
        end
    end

    sram_ctrl_fifo #(
        .DEPTH (REQ_DEPTH),
        .T     (req_t)
    ) u_req_fifo (
        .driver_clk (driver_clk),
        .resetn     (resetn),
        .push       (req_push),
        .push_data  (req_push_data),
        .pop        (issue),
        .head       (req_head),
        .count      (req_count)
    );

    sram_ctrl_fifo #(
        .DEPTH (2),
        .T     (rsp_t)
    ) u_rsp_fifo (
        .driver_clk (driver_clk),
        .resetn     (resetn),
        .push       (inflight_q),
        .push_data  (rsp_push_data),
        .pop        (rsp_pop),
        .head       (rsp_head),
        .count      (rsp_count)
    );

endmodule

// File: doc/sram_access_ctrl.md
# sram_access_ctrl

Request-side controller that sits directly upstream of the 8x32 flip-flop SRAM and drives its address, write-enable and write-data pins. It accepts read/write requests from a client over a valid/ready handshake and queues them in a request FIFO. It issues one SRAM operation per cycle, in order, and returns read data through a 2-entry response FIFO with its own valid/ready handshake, sustaining full throughput despite the SRAM's 1-cycle read latency.

## Interface
- ADDR_W, 3, SRAM address width (8 words)
- DATA_W, 32, SRAM data width
- REQ_DEPTH, 4, request FIFO depth (power of 2, ≥2)
- driver_clk  in  1  clock, all state on rising edge
- resetn  in  1  reset, asynchronous, active-high
- req_valid  in  1  client request valid
- req_ready  out  1  request FIFO can accept
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  client accepts response
- rsp_addr  out  ADDR_W  address of returned read
- rsp_rdata  out  DATA_W  read data
- mem_add  out  ADDR_W  to SRAM address
- mem_we  out  1  to SRAM write enable
- mem_wd  out  DATA_W  to SRAM write data
- mem_rd  in  DATA_W  from SRAM read data, valid the cycle after the read address is sampled
- busy  out  1  any request queued, read in flight, or response pending

## Operation
- Accept: req_valid && req_ready at an edge pushes {we, addr, wdata}. req_ready = (req_count != REQ_DEPTH) and resetn deasserted; no bypass when full.
- Issue: the head is presented combinationally on mem_add/mem_wd; mem_we = head.we && issue. Head pops at the edge where issue is true.
- A write issues whenever the request FIFO is non-empty.
- A read issues only if credit is available: rsp_count + inflight < 2, where rsp_count already accounts for a pop at the same edge. A blocked read stalls the head; later requests never pass it.
- Read issue at edge N sets inflight with the captured addr. At edge N+1, mem_rd and addr are pushed into the response FIFO and inflight clears unless a new read issued at N+1.
- Idle outputs: mem_we=0, mem_add=0, mem_wd=0.
- Ordering: a read after a write to the same address returns the new data, because the write is sampled at edge N and the read at N+1 or later.
- Reset: the request FIFO, response FIFO and inflight all clear. Any accepted-but-unissued request and any in-flight read are dropped. SRAM contents are not touched.
- Reset values: req_ready=0 while reset asserted, then 1. rsp_valid=0, rsp_addr=0, rsp_rdata=0, mem_we=0, mem_add=0, mem_wd=0, busy=0.

## Timing
- Request accepted at edge E → SRAM op sampled at E+1 at the earliest.
- Read: mem_rd valid in cycle E+1..E+2 → captured at E+2 → rsp_valid high from just after E+2. Minimum request-to-response latency is 2 cycles.
- Throughput: 1 op/cycle while rsp_ready=1. With rsp_ready=0, at most 2 reads complete, then reads stall. Writes also stall if a read is stalled ahead of them.
- rsp_valid stays high, and rsp_addr/rsp_rdata stay stable, until rsp_ready.
- Simultaneous push and pop on either FIFO: count is unchanged and data is preserved. Pointers wrap modulo depth.

## Structure
- Package sram_ctrl_pkg: ADDR_W, DATA_W, req_t struct {we, addr, wdata}, rsp_t struct {addr, rdata}.
- Sub-module sram_ctrl_fifo: parameterized synchronous FIFO with count output and async active-high reset. Instantiated once for requests (REQ_DEPTH, req_t) and once for responses (depth 2, rsp_t).
- Issue/credit logic and the inflight register live in the top module.

## Test plan
- Reset then write addr 3 = 0xDEADBEEF, read addr 3 with rsp_ready=1 → mem_we=1/mem_add=3 one cycle after accept; rsp_valid 2 cycles after the read accept, rsp_rdata=0xDEADBEEF, rsp_addr=3.
- Back-to-back write 5=0x12345678, read 5 on consecutive cycles → the read returns 0x12345678 (read-after-write ordering).
- Hold rsp_ready=0, issue 4 reads (addr 0..3 preloaded with 0x10..0x13) → 2 responses buffered and the third read stalls at the head. Raise rsp_ready → responses 0x10, 0x11, 0x12, 0x13 in order, none lost.
- Push 4 writes with no issue possible behind a stalled read → req_ready=0 when req_count=4. A push attempt while full is ignored; the FIFO drains in order once unstalled.
- Streaming 100 random ops with rsp_ready=1 → 1 op/cycle, all reads match a reference model, 0 errors.
- Assert resetn with a read in flight and 3 requests queued → next cycle rsp_valid=0, busy=0, mem_we=0. The dropped read produces no response, and earlier SRAM writes still read back correctly after reset.
